seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 22 ++
 rtl/seg7_hex_decode.sv | 45 ++++
 rtl/seg7_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: segment bit order,
// the dark-segment constant and the scan FSM state encoding.
package seg7_pkg;

  // Bit position of each segment inside the {a,b,c,d,e,f,g} vector.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-segment decoder, active-low output in {a..g} order.
// One instance is shared by all digits of the scan controller.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg_n
);

  localparam logic [6:0] SA = 7'b1 << SEG_A;
  localparam logic [6:0] SB = 7'b1 << SEG_B;
  localparam logic [6:0] SC = 7'b1 << SEG_C;
  localparam logic [6:0] SD = 7'b1 << SEG_D;
  localparam logic [6:0] SE = 7'b1 << SEG_E;
  localparam logic [6:0] SF = 7'b1 << SEG_F;
  localparam logic [6:0] SG = 7'b1 << SEG_G;

  logic [6:0] w_lit;

  always_comb begin
    w_lit = '0;
    unique case (i_hex)
      4'h0: w_lit = SA | SB | SC | SD | SE | SF;
      4'h1: w_lit = SB | SC;
      4'h2: w_lit = SA | SB | SD | SE | SG;
      4'h3: w_lit = SA | SB | SC | SD | SG;
      4'h4: w_lit = SB | SC | SF | SG;
      4'h5: w_lit = SA | SC | SD | SF | SG;
      4'h6: w_lit = SA | SC | SD | SE | SF | SG;
      4'h7: w_lit = SA | SB | SC;
      4'h8: w_lit = SA | SB | SC | SD | SE | SF | SG;
      4'h9: w_lit = SA | SB | SC | SD | SF | SG;
      4'hA: w_lit = SA | SB | SC | SE | SF | SG;
      4'hB: w_lit = SC | SD | SE | SF | SG;
      4'hC: w_lit = SA | SD | SE | SF;
      4'hD: w_lit = SB | SC | SD | SE | SG;
      4'hE: w_lit = SA | SD | SE | SF | SG;
      4'hF: w_lit = SA | SE | SF | SG;
      default: w_lit = '0;
    endcase
  end

  assign o_seg_n = ~w_lit;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Frame-synchronous scan controller for a common-anode multi-digit display.
// Optional leading-zero blanking is enabled by SEG7_LEADING_ZERO_BLANK_EN.
//
//   state    | meaning
//   ST_OFF   | scan disabled, display dark, counters held at 0
//   ST_BLANK | first cycle of a slot, anodes off, segments loaded
//   ST_DRIVE | rest of the slot, anode idx driven, segments held
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  scan_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_disp, r_pend, w_disp_nxt;
  logic                    r_pend_v;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic                    r_frame_done;

  logic       w_frame_end, w_apply, w_accept, w_blank_lz;
  logic [3:0] w_nibble;
  logic [6:0] w_glyph;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    if (!en) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
        ST_BLANK: begin
          w_state_nxt = ST_DRIVE;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
        ST_DRIVE: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  // A pending value lands at a frame edge, or at once when nothing is being scanned.
  assign w_frame_end = (r_state == ST_DRIVE) && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);
  assign w_apply     = r_pend_v && ((r_state == ST_OFF) || w_frame_end);
  assign w_accept    = wr_valid && !r_pend_v;
  assign w_disp_nxt  = w_apply ? r_pend : r_disp;
  assign w_nibble    = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .i_hex   (w_nibble),
    .o_seg_n (w_glyph)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    w_blank_lz = (w_idx_nxt != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(w_idx_nxt)) && (w_disp_nxt[4*k +: 4] != 4'h0)) w_blank_lz = 1'b0;
    end
  end
`else
  assign w_blank_lz = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_disp   <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      if (w_apply) begin
        r_disp   <= r_pend;
        r_pend_v <= 1'b0;
      end
      if (w_accept) begin
        r_pend   <= wr_value;
        r_pend_v <= 1'b1;
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= '1;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (w_state_nxt == ST_DRIVE) && (w_cnt_nxt == CNT_LAST) &&
                      (w_idx_nxt == IDX_LAST);
      unique case (w_state_nxt)
        ST_BLANK: begin
          r_an  <= '1;
          r_seg <= w_blank_lz ? SEG_OFF : w_glyph;
          r_dp  <= ~dp_mask[w_idx_nxt];
        end
        ST_DRIVE: r_an <= ~(AN_ONE << w_idx_nxt);
        default: begin
          r_an  <= '1;
          r_seg <= SEG_OFF;
          r_dp  <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready   = !r_pend_v;
  assign an_n       = r_an;
  assign seg_n      = r_seg;
  assign dp_n       = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl (4 digits, 4-cycle slots): directed scenarios plus
// random traffic, all outputs compared every cycle against a time-position model.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int TD    = 4;
  localparam int FRAME = N * TD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_value = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(N), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_value   (wr_value),
    .dp_mask    (dp_mask),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  int n_vec = 0;
  int n_miscmp = 0;

  // Reference model: scanning flag, cycles since scan start, stored values.
  bit          m_on = 1'b0;
  int          m_t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  bit          m_pend_v = 1'b0;
  logic [6:0]  m_seg = 7'h7F;
  bit          m_dp = 1'b1;
  bit          m_acc = 1'b0;

  // Lit segments of each hex glyph.
  string font [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph_n(input logic [3:0] h);
    logic [6:0] lit;
    string s;
    lit = '0;
    s = font[h];
    for (int i = 0; i < s.len(); i++) lit[6 - (int'(s[i]) - 97)] = 1'b1;
    return ~lit;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_on = 1'b0; m_t = 0; m_disp = '0; m_pend_v = 1'b0;
    m_seg = 7'h7F; m_dp = 1'b1; m_acc = 1'b0;
  endtask

  task automatic cycle();
    bit   ready_b, fe_b, lz;
    int   dig, pos;
    logic [3:0] exp_an;
    @(posedge clk);
    ready_b = !m_pend_v;
    fe_b    = m_on && ((m_t % FRAME) == FRAME - 1);
    m_acc   = wr_valid && ready_b;
    if (m_pend_v && (!m_on || fe_b)) begin
      m_disp   = m_pend;
      m_pend_v = 1'b0;
    end
    if (m_acc) begin
      m_pend   = wr_value;
      m_pend_v = 1'b1;
    end
    if (!en) m_on = 1'b0;
    else if (!m_on) begin m_on = 1'b1; m_t = 0; end
    else m_t++;
    pos = m_t % TD;
    dig = (m_t / TD) % N;
    if (!m_on) begin
      m_seg = 7'h7F; m_dp = 1'b1;
    end else if (pos == 0) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz = (dig > 0) && ((m_disp >> (4 * dig)) == 16'h0);
`else
      lz = 1'b0;
`endif
      m_seg = lz ? 7'h7F : glyph_n(m_disp[4*dig +: 4]);
      m_dp  = !dp_mask[dig];
    end
    exp_an = (m_on && pos != 0) ? ~(4'b0001 << dig) : 4'hF;
    @(negedge clk);
    check_eq("an_n", 16'(an_n), 16'(exp_an));
    check_eq("seg_n", 16'(seg_n), 16'(m_seg));
    check_eq("dp_n", 16'(dp_n), 16'(m_dp));
    check_eq("frame_done", 16'(frame_done), 16'(m_on && (m_t % FRAME) == FRAME - 1));
    check_eq("wr_ready", 16'(wr_ready), 16'(!m_pend_v));
  endtask

  task automatic write_hold(input logic [15:0] v);
    int budget;
    wr_valid = 1'b1;
    wr_value = v;
    budget = 200;
    do begin
      cycle();
      budget--;
    end while (!m_acc && budget > 0);
    if (!m_acc) check_eq("wr_accept_timeout", 16'd0, 16'd1);
    wr_valid = 1'b0;
  endtask

  task automatic run_until_pos(input int frame_pos);
    int budget;
    budget = 200;
    while (!(m_on && (m_t % FRAME) == frame_pos) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) check_eq("position_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_an_n", 16'(an_n), 16'hF);
    check_eq("rst_seg_n", 16'(seg_n), 16'h7F);
    check_eq("rst_dp_n", 16'(dp_n), 16'h1);
    check_eq("rst_wr_ready", 16'(wr_ready), 16'h1);
    check_eq("rst_frame_done", 16'(frame_done), 16'h0);
    model_reset();
    rst_n = 1'b1;

    // Write while off, then scan 12AF.
    write_hold(16'h12AF);
    repeat (2) cycle();
    en = 1'b1;
    repeat (40) cycle();

    // Tear-free update.
    write_hold(16'h1234);
    repeat (34) cycle();
    run_until_pos(6);
    write_hold(16'h0000);
    repeat (40) cycle();

    // Back-pressure with two consecutive values.
    write_hold(16'hA5C3);
    write_hold(16'h0F0F);
    repeat (40) cycle();

    // Enable drop during digit 2, write while off, re-enable.
    dp_mask = 4'b0101;
    run_until_pos(2 * TD + 2);
    en = 1'b0;
    repeat (3) cycle();
    write_hold(16'hBEEF);
    repeat (2) cycle();
    en = 1'b1;
    repeat (20) cycle();

    // Leading-zero pattern with decimal point on digit 3.
    dp_mask = 4'b1000;
    write_hold(16'h0050);
    repeat (40) cycle();

    // Asynchronous reset mid-DRIVE with a value pending.
    write_hold(16'h9999);
    run_until_pos(TD + 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_an_n", 16'(an_n), 16'hF);
    check_eq("rst_mid_seg_n", 16'(seg_n), 16'h7F);
    check_eq("rst_mid_wr_ready", 16'(wr_ready), 16'h1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) cycle();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      dp_mask = 4'($urandom);
      if (en) begin
        if ($urandom_range(63) == 0) en = 1'b0;
      end else if ($urandom_range(7) == 0) en = 1'b1;
      if (wr_valid && m_acc) wr_valid = 1'b0;
      if (!wr_valid && $urandom_range(15) == 0) begin
        wr_valid = 1'b1;
        wr_value = 16'($urandom) >> $urandom_range(15);
      end
      cycle();
    end
    wr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
